// File: rtl/irq_pkg.sv
// Shared types and constants for the interrupt priority controller and its
// helpers.
package irq_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ASSERT  = 2'd1,
    SERVICE = 2'd2
  } irq_state_t;

  localparam logic MODE_LEVEL = 1'b0;
  localparam logic MODE_EDGE  = 1'b1;

endpackage

// File: rtl/irq_priority_ctrl_if.sv
// Register-write, source and CPU handshake signals of the interrupt controller.
// The master is the peripheral/CPU side and the slave is the controller.
interface irq_priority_ctrl_if #(
  parameter int NUM_SRC = 8
);
  localparam int ID_W = $clog2(NUM_SRC);

  logic [NUM_SRC-1:0] src;
  logic               enable_we;
  logic [NUM_SRC-1:0] enable_wdata;
  logic               mode_we;
  logic [NUM_SRC-1:0] mode_wdata;
  logic               clear_we;
  logic [NUM_SRC-1:0] clear_wdata;
  logic               ack;
  logic               eoi;
  logic               irq;
  logic [ID_W-1:0]    irq_id;
  logic [NUM_SRC-1:0] pending;
  logic               busy;

  modport master (
    output src, enable_we, enable_wdata, mode_we, mode_wdata,
           clear_we, clear_wdata, ack, eoi,
    input  irq, irq_id, pending, busy
  );

  modport slave (
    input  src, enable_we, enable_wdata, mode_we, mode_wdata,
           clear_we, clear_wdata, ack, eoi,
    output irq, irq_id, pending, busy
  );
endinterface

// File: rtl/irq_priority_ctrl_prio_enc.sv
// Lowest-index-first priority encoder: bit 0 is the highest priority.
module prio_enc #(
  parameter int NUM_SRC = 8
) (
  input  logic [NUM_SRC-1:0]         req,
  output logic                       valid,
  output logic [$clog2(NUM_SRC)-1:0] idx
);
  localparam int ID_W = $clog2(NUM_SRC);

  always_comb begin
    valid = |req;
    idx   = '0;
    // Scan downwards so the lowest set index is the last one written.
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (req[i]) idx = ID_W'(i);
    end
  end
endmodule

// File: rtl/irq_priority_ctrl.sv
// Pending/enable/mode interrupt combiner with fixed-priority selection and a
// registered irq/irq_id toward the CPU using an ack / end-of-interrupt handshake.
module irq_priority_ctrl
  import irq_pkg::*;
#(
  parameter int NUM_SRC = 8
) (
  input logic               clk,
  input logic               reset,
  irq_priority_ctrl_if.slave bus
);
  localparam int ID_W = $clog2(NUM_SRC);

  logic [NUM_SRC-1:0] src_q, src_d;
  logic [NUM_SRC-1:0] enable_q, enable_d;
  logic [NUM_SRC-1:0] mode_q, mode_d;
  logic [NUM_SRC-1:0] pending_q, pending_d;
  logic [NUM_SRC-1:0] rise, clr_mask, masked;
  irq_state_t         state_q, state_d;
  logic               irq_q, irq_d;
  logic               busy_q, busy_d;
  logic [ID_W-1:0]    irq_id_q, irq_id_d;
  logic               ack_take;
  logic               win_valid;
  logic [ID_W-1:0]    win_idx;

  assign ack_take = (state_q == ASSERT) && bus.ack;
  assign rise     = bus.src & ~src_q;
  assign masked   = pending_q & enable_q;

  always_comb begin
    src_d    = bus.src;
    enable_d = bus.enable_we ? bus.enable_wdata : enable_q;
    mode_d   = bus.mode_we ? bus.mode_wdata : mode_q;
    clr_mask = bus.clear_we ? bus.clear_wdata : '0;
    if (ack_take) clr_mask[irq_id_q] = 1'b1;
  end

  // Edge-mode bits: a new rise beats any clear arriving on the same edge.
  for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_pend
    assign pending_d[gi] = (mode_q[gi] == MODE_LEVEL) ? bus.src[gi]
                         : (rise[gi] | (pending_q[gi] & ~clr_mask[gi]));
  end

  prio_enc #(.NUM_SRC(NUM_SRC)) u_prio_enc (
    .req   (masked),
    .valid (win_valid),
    .idx   (win_idx)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      src_q     <= '0;
      enable_q  <= '0;
      mode_q    <= '0;
      pending_q <= '0;
      state_q   <= IDLE;
      irq_q     <= 1'b0;
      irq_id_q  <= '0;
      busy_q    <= 1'b0;
    end else begin
      src_q     <= src_d;
      enable_q  <= enable_d;
      mode_q    <= mode_d;
      pending_q <= pending_d;
      state_q   <= state_d;
      irq_q     <= irq_d;
      irq_id_q  <= irq_id_d;
      busy_q    <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (win_valid) state_d = ASSERT;
      ASSERT: begin
        if (bus.ack)                  state_d = SERVICE;
        else if (!masked[irq_id_q])   state_d = IDLE;
      end
      SERVICE: if (bus.eoi) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // irq_id is only reloaded from IDLE, so no pre-emption once presented.
  always_comb begin
    irq_d    = irq_q;
    irq_id_d = irq_id_q;
    busy_d   = busy_q;
    case (state_q)
      IDLE: begin
        if (win_valid) begin
          irq_d    = 1'b1;
          irq_id_d = win_idx;
        end
      end
      ASSERT: begin
        if (bus.ack) begin
          irq_d  = 1'b0;
          busy_d = 1'b1;
        end else if (!masked[irq_id_q]) begin
          irq_d = 1'b0;
        end
      end
      SERVICE: if (bus.eoi) busy_d = 1'b0;
      default: begin
        irq_d  = 1'b0;
        busy_d = 1'b0;
      end
    endcase
  end

  assign bus.irq     = irq_q;
  assign bus.irq_id  = irq_id_q;
  assign bus.pending = pending_q;
  assign bus.busy    = busy_q;
endmodule

// File: tb/tb_irq_priority_ctrl.sv
// Directed scenarios plus randomized traffic, each cycle compared against a
// rule-level reference model of the interrupt controller.
module tb_irq_priority_ctrl;
  localparam int N = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  irq_priority_ctrl_if #(.NUM_SRC(N)) bus ();

  irq_priority_ctrl #(.NUM_SRC(N)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: phase 0 = waiting, 1 = presenting, 2 = being serviced.
  int       m_phase;
  bit [N-1:0] m_pend, m_en, m_mode, m_prev;
  bit       m_irq, m_busy;
  int       m_id;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_pend = '0; m_en = '0; m_mode = '0; m_prev = '0;
    m_irq = 0; m_busy = 0; m_id = 0;
  endtask

  task automatic compare_all(input string where);
    check({where, ".irq"},     32'(bus.irq),     32'(m_irq));
    check({where, ".irq_id"},  32'(bus.irq_id),  32'(m_id));
    check({where, ".pending"}, 32'(bus.pending), 32'(m_pend));
    check({where, ".busy"},    32'(bus.busy),    32'(m_busy));
  endtask

  // One clock: predict from the current inputs, clock, then compare.
  task automatic step(input string where);
    bit [N-1:0] np, enabled_pending;
    int         nphase, nid, win;
    bit         nirq, nbusy, accepted;
    if (reset) begin
      @(posedge clk); #1;
      model_reset();
      compare_all(where);
      return;
    end
    enabled_pending = m_pend & m_en;
    accepted = (m_phase == 1) && bus.ack;
    for (int i = 0; i < N; i++) begin
      if (!m_mode[i]) np[i] = bus.src[i];
      else if (bus.src[i] && !m_prev[i]) np[i] = 1'b1;
      else if ((bus.clear_we && bus.clear_wdata[i]) || (accepted && m_id == i)) np[i] = 1'b0;
      else np[i] = m_pend[i];
    end
    nphase = m_phase; nid = m_id; nirq = m_irq; nbusy = m_busy;
    if (m_phase == 0) begin
      win = -1;
      for (int i = 0; i < N; i++) if (win < 0 && enabled_pending[i]) win = i;
      if (win >= 0) begin nphase = 1; nirq = 1; nid = win; end
    end else if (m_phase == 1) begin
      if (bus.ack) begin nphase = 2; nirq = 0; nbusy = 1; end
      else if (!enabled_pending[m_id]) begin nphase = 0; nirq = 0; end
    end else begin
      if (bus.eoi) begin nphase = 0; nbusy = 0; end
    end
    if (bus.enable_we) m_en = bus.enable_wdata;
    if (bus.mode_we)   m_mode = bus.mode_wdata;
    m_prev = bus.src;
    @(posedge clk); #1;
    m_pend = np; m_phase = nphase; m_id = nid; m_irq = nirq; m_busy = nbusy;
    compare_all(where);
  endtask

  task automatic idle_inputs();
    bus.enable_we = 0; bus.enable_wdata = '0;
    bus.mode_we = 0;   bus.mode_wdata = '0;
    bus.clear_we = 0;  bus.clear_wdata = '0;
    bus.ack = 0;       bus.eoi = 0;
  endtask

  task automatic write_regs(input bit [N-1:0] en, input bit [N-1:0] md);
    bus.enable_we = 1; bus.enable_wdata = en;
    bus.mode_we = 1;   bus.mode_wdata = md;
    step("wr");
    idle_inputs();
  endtask

  initial begin
    model_reset();
    idle_inputs();
    bus.src = 8'hFF;

    // 1: source held high through reset, all sources disabled
    step("rst"); step("rst");
    check("rst.busy", 32'(bus.busy), 0);
    reset = 0;
    step("t1");
    check("t1.pending_ff", 32'(bus.pending), 32'hFF);
    for (int i = 0; i < 10; i++) begin
      step("t1");
      check("t1.irq_quiet", 32'(bus.irq), 0);
    end

    // 2: single edge pulse, full handshake
    bus.src = 8'h00; step("t2");
    write_regs(8'hFF, 8'hFF);
    bus.src = 8'h20; step("t2");
    check("t2.pend5", 32'(bus.pending[5]), 1);
    check("t2.irq_early", 32'(bus.irq), 0);
    bus.src = 8'h00; step("t2");
    check("t2.irq", 32'(bus.irq), 1);
    check("t2.id", 32'(bus.irq_id), 5);
    bus.ack = 1; step("t2");
    check("t2.pend5_clr", 32'(bus.pending[5]), 0);
    check("t2.busy", 32'(bus.busy), 1);
    bus.ack = 0; bus.eoi = 1; step("t2");
    check("t2.busy_off", 32'(bus.busy), 0);
    bus.eoi = 0; step("t2");
    check("t2.irq_off", 32'(bus.irq), 0);

    // 3: priority and no pre-emption
    bus.src = 8'h44; step("t3");
    bus.src = 8'h00; step("t3");
    check("t3.id2", 32'(bus.irq_id), 2);
    bus.ack = 1; step("t3");
    bus.ack = 0; bus.eoi = 1; step("t3");
    bus.eoi = 0; step("t3");
    check("t3.irq6", 32'(bus.irq), 1);
    check("t3.id6", 32'(bus.irq_id), 6);
    bus.src = 8'h01; step("t3");
    bus.src = 8'h00;
    for (int i = 0; i < 3; i++) begin
      step("t3");
      check("t3.hold6", 32'(bus.irq_id), 6);
    end
    bus.ack = 1; step("t3");
    bus.ack = 0; bus.eoi = 1; step("t3");
    bus.eoi = 0; step("t3");
    check("t3.id0", 32'(bus.irq_id), 0);
    bus.ack = 1; step("t3");
    bus.ack = 0; bus.eoi = 1; step("t3");
    bus.eoi = 0;

    // 4: level-mode withdrawal before ack
    write_regs(8'hFF, 8'h00);
    bus.src = 8'h08; step("t4"); step("t4");
    check("t4.id3", 32'(bus.irq_id), 3);
    bus.src = 8'h00; step("t4");
    check("t4.pend3", 32'(bus.pending[3]), 0);
    step("t4");
    check("t4.irq_drop", 32'(bus.irq), 0);
    bus.ack = 1; step("t4");
    check("t4.ack_ignored", 32'(bus.busy), 0);
    bus.ack = 0;

    // 5: set beats clear on the same edge
    write_regs(8'h00, 8'hFF);
    bus.src = 8'h10; step("t5");
    bus.src = 8'h00; step("t5");
    bus.src = 8'h10; bus.clear_we = 1; bus.clear_wdata = 8'h10; step("t5");
    check("t5.set_wins", 32'(bus.pending[4]), 1);
    step("t5");
    check("t5.cleared", 32'(bus.pending[4]), 0);
    idle_inputs(); bus.src = 8'h00; step("t5");

    // 6: asynchronous reset in SERVICE
    write_regs(8'hFF, 8'hFF);
    bus.src = 8'h02; step("t6");
    bus.src = 8'h00; step("t6");
    bus.ack = 1; step("t6");
    bus.ack = 0;
    check("t6.busy_pre", 32'(bus.busy), 1);
    #2 reset = 1;
    #1;
    check("t6.busy_async", 32'(bus.busy), 0);
    check("t6.irq_async", 32'(bus.irq), 0);
    check("t6.pend_async", 32'(bus.pending), 0);
    model_reset();
    bus.src = 8'h0F;
    step("t6");
    reset = 0;
    for (int i = 0; i < 10; i++) begin
      bus.src = N'($urandom);
      step("t6");
      check("t6.no_irq", 32'(bus.irq), 0);
    end

    // Randomized traffic
    for (int c = 0; c < 1500; c++) begin
      bus.src = N'($urandom);
      bus.enable_we = ($urandom_range(0, 15) == 0);
      bus.enable_wdata = N'($urandom);
      bus.mode_we = ($urandom_range(0, 15) == 0);
      bus.mode_wdata = N'($urandom);
      bus.clear_we = ($urandom_range(0, 7) == 0);
      bus.clear_wdata = N'($urandom);
      bus.ack = ($urandom_range(0, 2) == 0);
      bus.eoi = ($urandom_range(0, 2) == 0);
      step("rnd");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
